// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel synchroniser + saturating stability filter with press/release pulses.
// Optional auto-repeat of btn_press while held is enabled by defining DEBOUNCE_REPEAT_EN.
module debounce_bank #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 3,
    parameter int CNT_W       = 8,
    parameter int REPEAT_CNT  = 50
) (
    input  logic                clk_debouncer,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release
);
    if (2**CNT_W <= STABLE_CNT || 2**CNT_W <= REPEAT_CNT) begin : g_cnt_w_check
        $error("CNT_W too narrow for STABLE_CNT/REPEAT_CNT");
    end
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] s, acc, level_d, press_d, release_d;
`ifdef DEBOUNCE_REPEAT_EN
    logic [CNT_W-1:0]    rcnt_q [CHANNELS];
    logic [CNT_W-1:0]    rcnt_d [CHANNELS];
    logic [CHANNELS-1:0] rep;
`endif
    assign s = sync_q[SYNC_STAGES-1];
    always_comb begin
        acc   = '0;
        cnt_d = cnt_q;
`ifdef DEBOUNCE_REPEAT_EN
        rep    = '0;
        rcnt_d = rcnt_q;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            // any agreeing sample restarts the count, so only an unbroken run is accepted
            acc[c]   = sample_en && s[c] != btn_level[c] && cnt_q[c] == CNT_W'(STABLE_CNT - 1);
            cnt_d[c] = !sample_en ? cnt_q[c] : (s[c] == btn_level[c] || acc[c]) ? '0 : cnt_q[c] + 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
            rep[c]    = sample_en && btn_level[c] && !acc[c] && rcnt_q[c] == CNT_W'(REPEAT_CNT - 1);
            rcnt_d[c] = (!btn_level[c] || acc[c] || rep[c]) ? '0 : sample_en ? rcnt_q[c] + 1'b1 : rcnt_q[c];
`endif
        end
        level_d   = btn_level ^ acc;
        release_d = acc & ~s;
`ifdef DEBOUNCE_REPEAT_EN
        press_d   = (acc & s) | rep;
`else
        press_d   = acc & s;
`endif
    end
    always_ff @(posedge clk_debouncer) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
`ifdef DEBOUNCE_REPEAT_EN
            for (int c = 0; c < CHANNELS; c++) rcnt_q[c] <= '0;
`endif
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            sync_q[0] <= btn;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            cnt_q       <= cnt_d;
`ifdef DEBOUNCE_REPEAT_EN
            rcnt_q      <= rcnt_d;
`endif
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
        end
    end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: scoreboard bench; expected pulses are queued at stimulus time and popped as the DUT emits them.
module tb_debounce_bank;
    localparam int CH = 4;
    localparam logic [CH-1:0] FORCE_ALL =
`ifdef DEBOUNCE_REPEAT_EN
        '0;
`else
        '1;
`endif
    logic          clk = 0, rst = 1, sample_en = 1;
    logic [CH-1:0] btn = '0, lvl, press, rel, watch = '1;
    bit            gated = 0;
    int            cyc = 0, checks = 0, errors = 0;
    int            exp_q [$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    debounce_bank #(.CHANNELS(CH), .REPEAT_CNT(4)) dut (
        .clk_debouncer(clk), .rst(rst), .sample_en(sample_en), .btn(btn),
        .btn_level(lvl), .btn_press(press), .btn_release(rel)
    );
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask
    function automatic int enc(input int c, input bit r, input int t);
        return t * 16 + c * 2 + int'(r);
    endfunction
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
            sample_en = gated ? (cyc % 4 == 3) : 1'b1;
        end
    endtask
    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask
    task automatic expect_pulse(input int c, input bit r, input int t);
        exp_q.push_back(enc(c, r, t));
    endtask
    task automatic start(input logic [CH-1:0] w);
        rst = 1; btn = '0; gated = 0; sample_en = 1;
        tick(2);
        chk("rst_state", {lvl, press, rel}, 0);
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        watch = w | FORCE_ALL;
        rst = 0;
    endtask
    always @(negedge clk) if (!rst) begin
        chk("excl", press & rel, 0);
        for (int c = 0; c < CH; c++)
            if (watch[c] && (press[c] || rel[c])) begin
                if (exp_q.size() == 0) chk("extra", enc(c, rel[c], cyc), -1);
                else chk("pulse", enc(c, rel[c], cyc), exp_q.pop_front());
            end
    end
    initial begin
        int c, e, n;
        bit [7:0] pat;
        // single press on channel 0
        start(4'b0001); c = cyc;
        btn[0] = 1; expect_pulse(0, 0, c + 5);
        wait_cyc(c + 4); chk("t1_pre", lvl, 0);
        wait_cyc(c + 5); chk("t1_lvl", lvl, 4'b0001); chk("t1_press", press, 4'b0001);
        wait_cyc(c + 6); chk("t1_once", press, 0);
        wait_cyc(c + 8);
        // bouncing input on channel 1: 1,0,1,1,0,1,1,1
        start(4'b0010); c = cyc;
        pat = 8'b1110_1101;
        expect_pulse(1, 0, c + 10);
        for (int j = 0; j < 8; j++) begin
            btn[1] = pat[j];
            tick();
        end
        wait_cyc(c + 9);  chk("t2_pre", lvl, 0);
        wait_cyc(c + 10); chk("t2_lvl", lvl, 4'b0010);
        wait_cyc(c + 12);
        // release on channel 2
        start(4'b0100); c = cyc;
        btn[2] = 1; expect_pulse(2, 0, c + 5);
        wait_cyc(c + 3); btn[2] = 0; expect_pulse(2, 1, c + 8);
        wait_cyc(c + 5); chk("t3_hi", lvl, 4'b0100);
        wait_cyc(c + 7); chk("t3_hold", lvl, 4'b0100);
        wait_cyc(c + 8); chk("t3_lvl", lvl, 0); chk("t3_rel", rel, 4'b0100);
        wait_cyc(c + 11);
        // gated sampling on channel 3
        start(4'b1000);
        gated = 1; sample_en = (cyc % 4 == 3); c = cyc;
        btn[3] = 1;
        e = c + 2; n = 0;
        while (n < 3) begin
            e++;
            if (e % 4 == 0) n++;
        end
        expect_pulse(3, 0, e);
        wait_cyc(e - 1); chk("t4_pre", lvl, 0);
        wait_cyc(e);     chk("t4_lvl", lvl, 4'b1000); chk("t4_press", press, 4'b1000);
        wait_cyc(e + 1); chk("t4_width", press, 0);
        wait_cyc(e + 6);
        gated = 0;
        // reset mid-count
        start(4'b0001); c = cyc;
        btn[0] = 1; expect_pulse(0, 0, c + 9);
        wait_cyc(c + 3); rst = 1; tick(); rst = 0;
        chk("t5_rst", {lvl, press}, 0);
        wait_cyc(c + 8); chk("t5_pre", lvl, 0);
        wait_cyc(c + 9); chk("t5_lvl", lvl, 4'b0001);
        wait_cyc(c + 11);
        // hold channel 1 (auto-repeat when enabled), then release
        start(4'b0010); c = cyc;
        btn[1] = 1; expect_pulse(1, 0, c + 5);
`ifdef DEBOUNCE_REPEAT_EN
        expect_pulse(1, 0, c + 9); expect_pulse(1, 0, c + 13);
`endif
        wait_cyc(c + 10); btn[1] = 0; expect_pulse(1, 1, c + 15);
        wait_cyc(c + 15); chk("t6_lvl", lvl, 0);
        wait_cyc(c + 25);
        // simultaneous transitions on all channels
        start('1); c = cyc;
        btn = '1;
        for (int k = 0; k < CH; k++) expect_pulse(k, 0, c + 5);
        wait_cyc(c + 3); btn = '0;
        for (int k = 0; k < CH; k++) expect_pulse(k, 1, c + 8);
        wait_cyc(c + 5); chk("t7_press", press, 4'b1111);
        wait_cyc(c + 8); chk("t7_rel", rel, 4'b1111); chk("t7_lvl", lvl, 0);
        wait_cyc(c + 10);
        chk("drain_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised multi-channel successor to the single-button debouncer.
- Synchronises CHANNELS raw button/switch inputs and filters each channel with a saturating stability counter clocked by a shared sample-enable tick.
- Produces a clean level per channel plus one-clock press/release pulses.
- Sits between the board pins and the stopwatch/control FSMs, which consume the pulses directly.

Parameters:
- CHANNELS, 4: number of independent inputs (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- STABLE_CNT, 3: consecutive differing samples required to accept a new level (>=1).
- CNT_W, 8: counter width; must satisfy 2^CNT_W > max(STABLE_CNT, REPEAT_CNT).
- REPEAT_CNT, 50: sample ticks per auto-repeat pulse. Used only with the optional feature.

Ports:
- clk_debouncer  in   1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- sample_en  in  1  sample tick; filter counters advance only when it is 1.
- btn  in  CHANNELS  raw asynchronous inputs; bit i is channel i.
- btn_level  out  CHANNELS  debounced level.
- btn_press  out  CHANNELS  one-clock pulse on accepted 0->1 (and on auto-repeat).
- btn_release  out  CHANNELS  one-clock pulse on accepted 1->0.

Behaviour:
- Clock and reset: one clock, clk_debouncer. rst is synchronous and active-high.
- Reset (rst=1 at a clock edge): all synchroniser flops, btn_level, counters, btn_press and btn_release go to 0 on that edge. rst has priority over every other event. Asserting rst mid-count discards partial counts and pulses; the output is 0 on the next cycle.
- Synchroniser: runs every clock regardless of sample_en. The synchronised bit is s_i = last stage.
- Filter, per channel, evaluated only on edges where sample_en=1:
  - s_i == btn_level[i]: cnt_i <= 0, no pulse. A single agreeing sample fully restarts the count (glitch rejection).
  - s_i != btn_level[i] and cnt_i < STABLE_CNT-1: cnt_i <= cnt_i+1.
  - s_i != btn_level[i] and cnt_i == STABLE_CNT-1: btn_level[i] <= s_i, cnt_i <= 0, and a one-clock pulse is emitted on btn_press[i] if s_i=1, else on btn_release[i].
- sample_en=0: cnt_i and btn_level hold; btn_press and btn_release are 0.
- Pulses are registered and last exactly one clk_debouncer cycle even when sample_en stays high.
- Latency with sample_en tied 1: btn changes before edge #1; btn_level and the pulse change at edge #(SYNC_STAGES+STABLE_CNT). Defaults give edge #5.
- STABLE_CNT=1: a level is accepted on the first differing sampled value.
- Channels are fully independent. Simultaneous transitions on several channels yield simultaneous pulses.
- btn_press and btn_release are never both high on one channel in the same cycle.
- Counters never wrap: cnt_i is bounded by STABLE_CNT-1.

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined:
  - Each channel has rcnt_i (CNT_W bits).
  - rcnt_i is cleared on reset, on any accepted level change, and whenever btn_level[i]=0.
  - On a sample_en edge with btn_level[i]=1 and no accepted change on that edge: if rcnt_i == REPEAT_CNT-1, pulse btn_press[i] and set rcnt_i <= 0; otherwise rcnt_i <= rcnt_i+1.
  - Result: while held, press repeats every REPEAT_CNT ticks after the initial press.
- Undefined: no repeat logic is synthesised and btn_press fires only on accepted 0->1 transitions. REPEAT_CNT is ignored.

Test Plan:
1. Reset, then defaults, sample_en=1, btn[0] 0->1 before edge #1 and held -> btn_level[0]=1 and btn_press[0]=1 for one cycle at edge #5; btn_release stays 0; other channels stay 0.
2. Bouncing: btn[1] pattern 1,0,1,1,0,1,1,1 then held high, one value per clock -> no pulse until three consecutive synced 1s; exactly one btn_press[1] pulse in total.
3. Release: channel 2 debounced high, btn[2] -> 0 -> btn_release[2] one cycle at edge #5, btn_level[2]=0, no press pulse.
4. Gated sampling: sample_en=1 every 4th clock, btn[3] rises -> btn_level[3] rises on the 3rd sample_en edge after s_3=1; pulse width exactly one clock.
5. Reset mid-count: btn[0] high, assert rst at edge #4 for one clock, keep btn high -> outputs 0 on edge #4; btn_level[0] rises SYNC_STAGES+STABLE_CNT edges after rst deasserts.
6. With DEBOUNCE_REPEAT_EN, REPEAT_CNT=4, sample_en=1, hold btn[1] -> initial press at edge #5, then presses at edges #9 and #13; release stops the repeats; without the macro, only the edge #5 press occurs.
